// File: rtl/psram_responder_pkg.sv
// Shared types and constants for the PSRAM/HyperRAM responder model.
// Holds the FSM encoding, CA layout constants and the CR0 latency decode.
package psram_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_REGW,
    ST_LAT,
    ST_WDATA,
    ST_RDATA,
    ST_HOLD
  } state_e;

  // CA field widths: row bits CA[33:16], column bits CA[2:0]
  localparam int CA_ROW_W = 18;
  localparam int CA_COL_W = 3;

  localparam logic [44:0] CR0_REG_CA     = 45'h0100_0000;
  localparam int          CR0_FIXED2X_BIT = 3;

  localparam logic [3:0] LAT_CODE_3 = 4'b1110;
  localparam logic [3:0] LAT_CODE_4 = 4'b1111;
  localparam logic [3:0] LAT_CODE_5 = 4'b0000;
  localparam logic [3:0] LAT_CODE_6 = 4'b0001;

  function automatic logic [2:0] lat_decode(input logic [3:0] code);
    case (code)
      LAT_CODE_3: lat_decode = 3'd3;
      LAT_CODE_4: lat_decode = 3'd4;
      LAT_CODE_5: lat_decode = 3'd5;
      LAT_CODE_6: lat_decode = 3'd6;
      default:    lat_decode = 3'd6;
    endcase
  endfunction

endpackage

// File: rtl/psram_responder_if.sv
// Pre-IO DDR byte-pair bus between PSRAM controller (master) and device (slave).
interface psram_responder_if;
  logic       cs_n;
  logic       ck_e;
  logic [7:0] dq_in_ris;
  logic [7:0] dq_in_fal;
  logic       rwds_in_ris;
  logic       rwds_in_fal;
  logic       refresh_req;
  logic [7:0] dq_out_ris;
  logic [7:0] dq_out_fal;
  logic       dq_oe;
  logic       rwds_out_ris;
  logic       rwds_out_fal;
  logic       rwds_oe;

  modport master (
    output cs_n, ck_e, dq_in_ris, dq_in_fal, rwds_in_ris, rwds_in_fal, refresh_req,
    input  dq_out_ris, dq_out_fal, dq_oe, rwds_out_ris, rwds_out_fal, rwds_oe
  );

  modport slave (
    input  cs_n, ck_e, dq_in_ris, dq_in_fal, rwds_in_ris, rwds_in_fal, refresh_req,
    output dq_out_ris, dq_out_fal, dq_oe, rwds_out_ris, rwds_out_fal, rwds_oe
  );
endinterface

// File: rtl/psram_responder_mem.sv
// Word memory for the responder: one byte lane per write enable, registered read.
module psram_responder_mem #(
  parameter int AW        = 10,
  parameter int NUM_LANES = 2
) (
  input  logic                      clk,
  input  logic [NUM_LANES-1:0]      we,
  input  logic                      re,
  input  logic [AW-1:0]             addr,
  input  logic [NUM_LANES-1:0][7:0] wdata,
  output logic [NUM_LANES-1:0][7:0] rdata
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] ram [2**AW];
    logic [7:0] rdata_q;

    // Contents are deliberately not reset; rdata_q holds while re is low
    always_ff @(posedge clk) begin
      if (we[l]) ram[addr] <= wdata[l];
      if (re)    rdata_q   <= ram[addr];
    end

    assign rdata[l] = rdata_q;
  end

endmodule

// File: rtl/psram_responder.sv
// HyperRAM/PSRAM device model at the controller's DDR byte boundary: decodes CA,
// applies CR0/refresh latency and serves memory and CR0 reads/writes.
module psram_responder
  import psram_responder_pkg::*;
#(
  parameter int          AW        = 10,
  parameter int          READ_PIPE = 6,
  parameter logic [15:0] CR0_RESET = 16'h8F1F
) (
  input  logic             clk,
  input  logic             resetn,
  psram_responder_if.slave bus,
  output logic [15:0]      cr0,
  output logic             busy
);

  state_e        state_q, state_d;
  logic [30:0]   ca_hi_q, ca_hi_d;   // {CA[47:46], CA[44:16]}; burst-type bit not kept
  logic          ca_cnt_q, ca_cnt_d;
  logic          is2x_q, is2x_d;
  logic [2:0]    lat_q, lat_d;
  logic          rd_q, rd_d, rs_q, rs_d, regw_hit_q, regw_hit_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   cr0_q, cr0_d;
  logic          dq_oe_q, dq_oe_d, rwds_oe_q, rwds_oe_d;
  logic          rwds_ris_q, rwds_ris_d, rwds_fal_q, rwds_fal_d;

  logic          beat;
  logic [15:0]   din;
  logic [CA_ROW_W+CA_COL_W-1:0] ca_waddr;
  logic [7:0]    lat_tot, pipe_add;
  logic [1:0]    mem_we;
  logic          mem_re;
  logic [15:0]   mem_rdata, rd_word;

  assign beat     = !bus.cs_n && bus.ck_e;
  assign din      = {bus.dq_in_ris, bus.dq_in_fal};
  assign ca_waddr = {ca_hi_q[CA_ROW_W-1:0], din[CA_COL_W-1:0]};
  assign lat_tot  = is2x_q ? {4'd0, lat_q, 1'b0} : {5'd0, lat_q};
  assign pipe_add = ca_hi_q[30] ? 8'(READ_PIPE) : 8'd0;

  always_comb begin
    state_d    = state_q;
    ca_hi_d    = ca_hi_q;
    ca_cnt_d   = ca_cnt_q;
    is2x_d     = is2x_q;
    lat_d      = lat_q;
    rd_d       = rd_q;
    rs_d       = rs_q;
    regw_hit_d = regw_hit_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    cr0_d      = cr0_q;
    dq_oe_d    = dq_oe_q;
    rwds_oe_d  = rwds_oe_q;
    rwds_ris_d = rwds_ris_q;
    rwds_fal_d = rwds_fal_q;
    mem_we     = 2'b00;
    mem_re     = 1'b0;

    if (bus.cs_n) begin
      state_d    = ST_IDLE;
      dq_oe_d    = 1'b0;
      rwds_oe_d  = 1'b0;
      rwds_ris_d = 1'b0;
      rwds_fal_d = 1'b0;
    end else if (beat) begin
      case (state_q)
        ST_IDLE: begin
          is2x_d          = cr0_q[CR0_FIXED2X_BIT] | bus.refresh_req;
          lat_d           = lat_decode(cr0_q[7:4]);
          ca_hi_d[30:16]  = {din[15:14], din[12:0]};
          ca_cnt_d        = 1'b0;
          rwds_oe_d       = 1'b1;
          rwds_ris_d      = is2x_d;
          rwds_fal_d      = is2x_d;
          state_d         = ST_CA;
        end
        ST_CA: begin
          if (!ca_cnt_q) begin
            ca_hi_d[15:0] = din;
            ca_cnt_d      = 1'b1;
          end else begin
            rd_d       = ca_hi_q[30];
            rs_d       = ca_hi_q[29];
            regw_hit_d = ({ca_hi_q[28:0], din} == CR0_REG_CA);
            addr_d     = AW'(ca_waddr);
            // Remaining latency beats after CA beat 3 before the first data beat
            cnt_d      = lat_tot + pipe_add - 8'd2;
            state_d    = (!ca_hi_q[30] && ca_hi_q[29]) ? ST_REGW : ST_LAT;
          end
        end
        ST_REGW: begin
          if (regw_hit_q) cr0_d = din;
          rwds_oe_d  = 1'b0;
          rwds_ris_d = 1'b0;
          rwds_fal_d = 1'b0;
          state_d    = ST_HOLD;
        end
        ST_LAT: begin
          if (cnt_q == 8'd0) begin
            addr_d = addr_q + 1'b1;
            if (rd_q) begin
              // RAM is sampled on this beat so data is ready as dq_oe rises
              mem_re     = 1'b1;
              dq_oe_d    = 1'b1;
              rwds_ris_d = 1'b1;
              rwds_fal_d = 1'b0;
              state_d    = ST_RDATA;
            end else begin
              mem_we     = ~{bus.rwds_in_ris, bus.rwds_in_fal};
              rwds_oe_d  = 1'b0;
              rwds_ris_d = 1'b0;
              rwds_fal_d = 1'b0;
              state_d    = ST_WDATA;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
            if (rd_q) begin
              rwds_ris_d = 1'b0;
              rwds_fal_d = 1'b0;
            end
          end
        end
        ST_WDATA: begin
          mem_we = ~{bus.rwds_in_ris, bus.rwds_in_fal};
          addr_d = addr_q + 1'b1;
        end
        ST_RDATA: begin
          mem_re = 1'b1;
          addr_d = addr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      ca_hi_q    <= '0;
      ca_cnt_q   <= 1'b0;
      is2x_q     <= 1'b0;
      lat_q      <= '0;
      rd_q       <= 1'b0;
      rs_q       <= 1'b0;
      regw_hit_q <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      cr0_q      <= CR0_RESET;
      dq_oe_q    <= 1'b0;
      rwds_oe_q  <= 1'b0;
      rwds_ris_q <= 1'b0;
      rwds_fal_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ca_hi_q    <= ca_hi_d;
      ca_cnt_q   <= ca_cnt_d;
      is2x_q     <= is2x_d;
      lat_q      <= lat_d;
      rd_q       <= rd_d;
      rs_q       <= rs_d;
      regw_hit_q <= regw_hit_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      cr0_q      <= cr0_d;
      dq_oe_q    <= dq_oe_d;
      rwds_oe_q  <= rwds_oe_d;
      rwds_ris_q <= rwds_ris_d;
      rwds_fal_q <= rwds_fal_d;
    end
  end

  psram_responder_mem #(.AW(AW), .NUM_LANES(2)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr_q),
    .wdata (din),
    .rdata (mem_rdata)
  );

  assign rd_word          = rs_q ? cr0_q : mem_rdata;
  assign bus.dq_out_ris   = dq_oe_q ? rd_word[15:8] : 8'h00;
  assign bus.dq_out_fal   = dq_oe_q ? rd_word[7:0]  : 8'h00;
  assign bus.dq_oe        = dq_oe_q;
  assign bus.rwds_out_ris = rwds_ris_q;
  assign bus.rwds_out_fal = rwds_fal_q;
  assign bus.rwds_oe      = rwds_oe_q;
  assign cr0              = cr0_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_psram_responder.sv
// Directed bench for psram_responder: driver pushes per-beat expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_psram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] cr0;
  logic        busy;

  psram_responder_if bus();

  psram_responder #(.AW(10), .READ_PIPE(6), .CR0_RESET(16'h8F1F)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .cr0    (cr0),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic        dq_oe;
    logic        rwds_oe;
    logic        rr;
    logic        rf;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_pass = 0;
  int          bn = 0;
  bit          last_beat = 1'b0;
  logic [15:0] bd [32];
  logic [1:0]  bm [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic ex(input int n, input logic dq_oe, input logic rwds_oe,
                    input logic rr, input logic rf, input logic [15:0] d);
    exp_t e;
    e.n = n; e.dq_oe = dq_oe; e.rwds_oe = rwds_oe; e.rr = rr; e.rf = rf; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic ex_ca(input logic v);
    for (int n = 1; n <= 3; n++) ex(n, 1'b0, 1'b1, v, v, 16'h0);
  endtask

  task automatic clr();
    for (int i = 0; i < 32; i++) begin
      bd[i] = 16'h5A5A;
      bm[i] = 2'b00;
    end
  endtask

  function automatic logic [47:0] mk_ca(input bit rd, input bit rs, input int wa);
    logic [20:0] a;
    a = 21'(wa);
    return {rd, rs, 1'b1, 11'b0, a[20:3], 13'b0, a[2:0]};
  endfunction

  // Drives beats 1..nb; optional ck_e stall before beat stall_at
  task automatic run(input logic [47:0] ca, input bit refr, input int nb,
                     input int stall_at, input int stall_len, input bit keep);
    for (int n = 1; n <= nb; n++) begin
      if (n == stall_at) begin
        bus.cs_n = 1'b0;
        bus.ck_e = 1'b0;
        repeat (stall_len) begin @(posedge clk); #1; end
      end
      bus.cs_n        = 1'b0;
      bus.ck_e        = 1'b1;
      bus.refresh_req = (n == 1) ? refr : 1'b0;
      bus.rwds_in_ris = 1'b0;
      bus.rwds_in_fal = 1'b0;
      case (n)
        1:       {bus.dq_in_ris, bus.dq_in_fal} = ca[47:32];
        2:       {bus.dq_in_ris, bus.dq_in_fal} = ca[31:16];
        3:       {bus.dq_in_ris, bus.dq_in_fal} = ca[15:0];
        default: begin
          {bus.dq_in_ris, bus.dq_in_fal}     = bd[n];
          {bus.rwds_in_ris, bus.rwds_in_fal} = bm[n];
        end
      endcase
      @(posedge clk); #1;
    end
    if (!keep) begin
      bus.cs_n = 1'b1;
      bus.ck_e = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Bench-side beat index, independent of the DUT
  always @(posedge clk) begin
    if (!resetn || bus.cs_n) bn = 0;
    else if (bus.ck_e)       bn = bn + 1;
    last_beat = resetn && !bus.cs_n && bus.ck_e;
  end

  always @(negedge clk) begin
    if (last_beat) begin
      if (exp_q.size() > 0 && exp_q[0].n == bn) begin
        mon_e = exp_q.pop_front();
        chk($sformatf("dq_oe@%0d", bn), 32'(bus.dq_oe), 32'(mon_e.dq_oe));
        chk($sformatf("rwds_oe@%0d", bn), 32'(bus.rwds_oe), 32'(mon_e.rwds_oe));
        if (mon_e.rwds_oe)
          chk($sformatf("rwds@%0d", bn), 32'({bus.rwds_out_ris, bus.rwds_out_fal}),
              32'({mon_e.rr, mon_e.rf}));
        if (mon_e.dq_oe)
          chk($sformatf("rdata@%0d", bn), 32'({bus.dq_out_ris, bus.dq_out_fal}),
              32'(mon_e.data));
      end else if (bus.dq_oe) begin
        chk($sformatf("unexpected_dq_oe@%0d", bn), 32'(bus.dq_oe), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    resetn          = 1'b1;
    bus.cs_n        = 1'b1;
    bus.ck_e        = 1'b0;
    bus.dq_in_ris   = 8'h00;
    bus.dq_in_fal   = 8'h00;
    bus.rwds_in_ris = 1'b0;
    bus.rwds_in_fal = 1'b0;
    bus.refresh_req = 1'b0;
    clr();
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cr0", 32'(cr0), 32'h8F1F);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_oe", 32'({bus.dq_oe, bus.rwds_oe}), 32'd0);
    chk("rst_out", 32'({bus.dq_out_ris, bus.dq_out_fal, bus.rwds_out_ris, bus.rwds_out_fal}), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // CR0 write; reset CR0 is fixed 2x so RWDS is high during CA
    clr(); bd[4] = 16'h8FE7;
    ex_ca(1'b1); ex(4, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    run(48'h6000_0100_0000, 1'b0, 4, 0, 0, 1'b0);
    chk("cr0_write", 32'(cr0), 32'h8FE7);
    chk("busy_idle", 32'(busy), 32'd0);

    // 1x write to byte 0x10 (word 8): data at beat 2+3
    clr(); bd[5] = 16'h1234;
    ex_ca(1'b0); ex(5, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    run(mk_ca(0, 0, 8), 1'b0, 5, 0, 0, 1'b0);
    ex_ca(1'b0); ex(4, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    ex(11, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234);
    run(mk_ca(1, 0, 8), 1'b0, 11, 0, 0, 1'b0);

    // Refresh collision forces 2x: beat 5 is latency, data at beat 8
    clr(); bd[5] = 16'h1111; bd[8] = 16'hBEEF;
    ex_ca(1'b1); ex(5, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0); ex(8, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    run(mk_ca(0, 0, 9), 1'b1, 8, 0, 0, 1'b0);
    ex_ca(1'b0); ex(11, 1'b1, 1'b1, 1'b1, 1'b0, 16'hBEEF);
    run(mk_ca(1, 0, 9), 1'b0, 11, 0, 0, 1'b0);

    // Lower byte masked; readback with a 3-cycle ck_e stall in latency
    clr(); bd[5] = 16'hAB00; bm[5] = 2'b01;
    ex_ca(1'b0);
    run(mk_ca(0, 0, 8), 1'b0, 5, 0, 0, 1'b0);
    ex(11, 1'b1, 1'b1, 1'b1, 1'b0, 16'hAB34);
    run(mk_ca(1, 0, 8), 1'b0, 11, 8, 3, 1'b0);

    // Burst across the top of memory wraps to word 0
    clr(); bd[5] = 16'hCAFE; bd[6] = 16'hF00D;
    run(mk_ca(0, 0, 1023), 1'b0, 6, 0, 0, 1'b0);
    ex(11, 1'b1, 1'b1, 1'b1, 1'b0, 16'hCAFE);
    ex(12, 1'b1, 1'b1, 1'b1, 1'b0, 16'hF00D);
    run(mk_ca(1, 0, 1023), 1'b0, 12, 0, 0, 1'b0);

    // Register write to a non-CR0 address is ignored; CR0 readback
    clr(); bd[4] = 16'h1234;
    run(48'h6000_0000_0000, 1'b0, 4, 0, 0, 1'b0);
    chk("cr0_ignored", 32'(cr0), 32'h8FE7);
    ex(11, 1'b1, 1'b1, 1'b1, 1'b0, 16'h8FE7);
    run(mk_ca(1, 1, 0), 1'b0, 11, 0, 0, 1'b0);

    // cs_n released mid-latency: no write happens
    clr(); bd[4] = 16'h0000;
    run(mk_ca(0, 0, 8), 1'b0, 4, 0, 0, 1'b0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rwds_oe", 32'(bus.rwds_oe), 32'd0);
    ex(11, 1'b1, 1'b1, 1'b1, 1'b0, 16'hAB34);
    ex(12, 1'b1, 1'b1, 1'b1, 1'b0, 16'hBEEF);
    run(mk_ca(1, 0, 8), 1'b0, 12, 0, 0, 1'b1);

    // Reset asserted mid-read
    @(negedge clk); #1;
    resetn = 1'b0;
    #1;
    chk("midrst_oe", 32'({bus.dq_oe, bus.rwds_oe}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cr0", 32'(cr0), 32'h8F1F);
    bus.cs_n = 1'b1;
    bus.ck_e = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Default CR0 (latency 6, fixed 2x): first read beat at 2+12+6
    ex_ca(1'b1); ex(19, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    ex(20, 1'b1, 1'b1, 1'b1, 1'b0, 16'hAB34);
    run(mk_ca(1, 0, 8), 1'b0, 20, 0, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
